sr_flop_jk: RTL and testbench
=============================

// Module: sr_flop_jk
// PURPOSE
// - Clocked SR flip-flop built on an internal JK flip-flop core (J = S, K = R).
// - Generic storage/control element: a bank of WIDTH independent SR bits with true and complement outputs.
// - Flags the forbidden S=R=1 input combination per bit so upstream logic can detect misuse.
// PARAMETERS
// - WIDTH        1  Number of independent SR bits.
// - FORBID_MODE  0  Response to S=R=1: 0 = toggle (native JK behaviour), 1 = hold, 2 = force reset.
// PORTS
// - clk      in   1      Clock; all state updates occur on the rising edge.
// - rst      in   1      Reset; asynchronous, active-high.
// - S        in   WIDTH  Set request, one bit per flop.
// - R        in   WIDTH  Reset request, one bit per flop.
// - Q        out  WIDTH  Stored state.
// - Q_bar    out  WIDTH  Complement of Q, always exactly ~Q.
// - forbid   out  WIDTH  Registered flag: the bit saw S=R=1 at the last rising edge.
// BEHAVIOUR
// - One clock, clk. Reset is asynchronous and active-high, port name rst.
// - Reset:
//   - While rst=1: Q=0, Q_bar=all ones, forbid=0, independent of clk, S and R.
//   - Deassertion takes effect from the next rising edge.
// - Per-bit next state at each rising clk edge, when rst=0:
//   - S=0, R=0: hold (Q unchanged).
//   - S=0, R=1: Q <= 0.
//   - S=1, R=0: Q <= 1.
//   - S=1, R=1: forbidden.
//     - FORBID_MODE=0: Q <= ~Q.
//     - FORBID_MODE=1: Q unchanged.
//     - FORBID_MODE=2: Q <= 0.
// - Internal JK core: J=S, K=R, next = (J & ~Q) | (~K & Q) for mode 0. Modes 1 and 2 override only the J=K=1 case.
// - forbid[i] <= S[i] & R[i] on every rising edge. It clears on the next edge where the condition is absent.
// - Latency: one edge. Inputs are sampled at the rising edge. Q, Q_bar and forbid update immediately after that edge.
// - Outputs are purely registered. There is no combinational path from S or R to any output.
// - Q_bar is derived from the Q register, never a separate flop. Q and Q_bar are never equal.
// - Bits are fully independent. A forbidden condition on one bit does not affect the others.
// - Input changes between edges have no effect.
// - Reset asserted mid-sequence overrides any pending set or toggle immediately.
// - Illegal FORBID_MODE values (3 and above) behave as mode 0.
// TESTING
// - Reset (WIDTH=1, mode 0):
//   - Assert rst for 2 cycles with S=1, R=0 -> Q=0, Q_bar=1, forbid=0 throughout.
//   - Release rst; next edge -> Q=1.
// - Hold, set and reset sequence, one edge each:
//   - S/R = 00, 01, 00, 10, 00 -> Q = 0, 0, 0, 1, 1; Q_bar always the complement.
// - Forbidden condition from Q=1, mode 0:
//   - S=R=1 for one edge -> Q=0, forbid=1.
//   - Then S=R=0 -> Q holds 0, forbid=0.
// - Forbidden condition in other modes:
//   - Mode 1 from Q=1: S=R=1 -> Q stays 1, forbid=1.
//   - Mode 2 from Q=1: S=R=1 -> Q=0, forbid=1.
// - Asynchronous reset mid-cycle:
//   - With Q=1, pulse rst between clock edges -> Q drops to 0 before the next edge.
//   - Q stays 0 after the pulse with S=R=0.
// - WIDTH=4:
//   - From Q=4'b0000, apply S=4'b1010, R=4'b0110 -> Q=4'b1000, forbid=4'b0010, Q_bar=4'b0111.

Source files
------------

// File: rtl/sr_flop_jk.sv
// Bank of WIDTH independent clocked SR flops on a JK core (J=S, K=R), with a registered S=R=1 flag.
// One-edge latency, purely registered outputs; no backpressure; asynchronous active-high reset.
module sr_flop_jk #(
    parameter int WIDTH       = 1,
    parameter int FORBID_MODE = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] S,
    input  logic [WIDTH-1:0] R,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] Q_bar,
    output logic [WIDTH-1:0] forbid
);

    logic [WIDTH-1:0] r_q;
    logic [WIDTH-1:0] r_forbid;
    logic [WIDTH-1:0] w_both;
    logic [WIDTH-1:0] w_jk_next;
    logic [WIDTH-1:0] w_q_next;

    assign w_both    = S & R;
    assign w_jk_next = (S & ~r_q) | (~R & r_q);

    // Modes 1 and 2 only replace the J=K=1 toggle; any other mode value keeps the JK toggle.
    always_comb begin
        w_q_next = w_jk_next;
        if (FORBID_MODE == 1) begin
            w_q_next = (w_both & r_q) | (~w_both & w_jk_next);
        end else if (FORBID_MODE == 2) begin
            w_q_next = ~w_both & w_jk_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q      <= '0;
            r_forbid <= '0;
        end else begin
            r_q      <= w_q_next;
            r_forbid <= w_both;
        end
    end

    // Q_bar comes from the same register so it can never disagree with Q.
    assign Q      = r_q;
    assign Q_bar  = ~r_q;
    assign forbid = r_forbid;

endmodule

// File: tb/tb_sr_flop_jk.sv
// Directed bench for sr_flop_jk: mode 0/1/2/illegal single-bit instances plus a 4-bit mode-2 bank.
module tb_sr_flop_jk;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic s0, r0, q0, qb0, f0;      // WIDTH=1, mode 0
    logic s1, r1, q1, qb1, f1;      // WIDTH=1, mode 1
    logic s2, r2, q2, qb2, f2;      // WIDTH=1, mode 2
    logic s3, r3, q3, qb3, f3;      // WIDTH=1, mode 3 (illegal -> mode 0)
    logic [3:0] s4, r4, q4, qb4, f4; // WIDTH=4, mode 2

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sr_flop_jk #(.WIDTH(1), .FORBID_MODE(0)) u0 (.clk(clk), .rst(rst), .S(s0), .R(r0), .Q(q0), .Q_bar(qb0), .forbid(f0));
    sr_flop_jk #(.WIDTH(1), .FORBID_MODE(1)) u1 (.clk(clk), .rst(rst), .S(s1), .R(r1), .Q(q1), .Q_bar(qb1), .forbid(f1));
    sr_flop_jk #(.WIDTH(1), .FORBID_MODE(2)) u2 (.clk(clk), .rst(rst), .S(s2), .R(r2), .Q(q2), .Q_bar(qb2), .forbid(f2));
    sr_flop_jk #(.WIDTH(1), .FORBID_MODE(3)) u3 (.clk(clk), .rst(rst), .S(s3), .R(r3), .Q(q3), .Q_bar(qb3), .forbid(f3));
    sr_flop_jk #(.WIDTH(4), .FORBID_MODE(2)) u4 (.clk(clk), .rst(rst), .S(s4), .R(r4), .Q(q4), .Q_bar(qb4), .forbid(f4));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        s0 = 1'b1; r0 = 1'b0;
        #2 rst = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_cmp++; if ({q0, qb0, f0} !== 3'b010) begin n_err++; $display("FAIL reset_hold cyc%0d: got q/qb/f=%b need 010", c, {q0, qb0, f0}); end
        end
        rst = 1'b0;
        tick();
        n_cmp++; if (q0 !== 1'b1) begin n_err++; $display("FAIL reset_release: got q=%b need 1", q0); end
    endtask

    task automatic test_hold_set_reset();
        logic [1:0] sr_vec [5];
        logic       q_exp  [5];
        sr_vec = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
        q_exp  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        s0 = 1'b0; r0 = 1'b0;
        pulse_reset();
        for (int i = 0; i < 5; i++) begin
            {s0, r0} = sr_vec[i];
            tick();
            n_cmp++; if ({q0, qb0} !== {q_exp[i], ~q_exp[i]}) begin n_err++; $display("FAIL seq_step%0d: got q/qb=%b need %b", i, {q0, qb0}, {q_exp[i], ~q_exp[i]}); end
        end
    endtask

    task automatic test_forbid_mode0();
        s0 = 1'b1; r0 = 1'b1;
        tick();
        n_cmp++; if ({q0, qb0, f0} !== 3'b011) begin n_err++; $display("FAIL forbid_m0_toggle: got q/qb/f=%b need 011", {q0, qb0, f0}); end
        s0 = 1'b0; r0 = 1'b0;
        tick();
        n_cmp++; if ({q0, f0} !== 2'b00) begin n_err++; $display("FAIL forbid_m0_clear: got q/f=%b need 00", {q0, f0}); end
    endtask

    task automatic test_forbid_other_modes();
        s1 = 1'b1; r1 = 1'b0; s2 = 1'b1; r2 = 1'b0; s3 = 1'b1; r3 = 1'b0;
        tick();
        n_cmp++; if ({q1, q2, q3} !== 3'b111) begin n_err++; $display("FAIL modes_preset: got q1/q2/q3=%b need 111", {q1, q2, q3}); end
        s1 = 1'b1; r1 = 1'b1; s2 = 1'b1; r2 = 1'b1; s3 = 1'b1; r3 = 1'b1;
        tick();
        n_cmp++; if ({q1, qb1, f1} !== 3'b101) begin n_err++; $display("FAIL forbid_m1_hold: got q/qb/f=%b need 101", {q1, qb1, f1}); end
        n_cmp++; if ({q2, qb2, f2} !== 3'b011) begin n_err++; $display("FAIL forbid_m2_reset: got q/qb/f=%b need 011", {q2, qb2, f2}); end
        n_cmp++; if ({q3, qb3, f3} !== 3'b011) begin n_err++; $display("FAIL forbid_m3_toggle: got q/qb/f=%b need 011", {q3, qb3, f3}); end
        // A second forbidden edge: mode 0 semantics toggle back to 1, mode 2 stays 0.
        tick();
        n_cmp++; if ({q1, q2, q3} !== 3'b101) begin n_err++; $display("FAIL forbid_second_edge: got q1/q2/q3=%b need 101", {q1, q2, q3}); end
        s1 = 1'b0; r1 = 1'b0; s2 = 1'b0; r2 = 1'b0; s3 = 1'b0; r3 = 1'b0;
    endtask

    task automatic test_async_reset();
        s0 = 1'b1; r0 = 1'b0;
        tick();
        n_cmp++; if (q0 !== 1'b1) begin n_err++; $display("FAIL async_preset: got q=%b need 1", q0); end
        s0 = 1'b1;
        #3 rst = 1'b1;
        #1;
        n_cmp++; if ({q0, qb0} !== 2'b01) begin n_err++; $display("FAIL async_midcycle: got q/qb=%b need 01", {q0, qb0}); end
        #1 rst = 1'b0;
        s0 = 1'b0; r0 = 1'b0;
        tick();
        n_cmp++; if ({q0, qb0} !== 2'b01) begin n_err++; $display("FAIL async_after: got q/qb=%b need 01", {q0, qb0}); end
    endtask

    task automatic test_between_edges();
        s0 = 1'b1; r0 = 1'b0;
        #1;
        n_cmp++; if (q0 !== 1'b0) begin n_err++; $display("FAIL no_comb_path: got q=%b need 0", q0); end
        #2 s0 = 1'b0;
        tick();
        n_cmp++; if (q0 !== 1'b0) begin n_err++; $display("FAIL glitch_ignored: got q=%b need 0", q0); end
    endtask

    task automatic test_width4();
        s4 = 4'b0000; r4 = 4'b0000;
        pulse_reset();
        n_cmp++; if ({q4, qb4, f4} !== 12'b0000_1111_0000) begin n_err++; $display("FAIL w4_reset: got q=%b qb=%b f=%b need 0000/1111/0000", q4, qb4, f4); end
        s4 = 4'b1010; r4 = 4'b0110;
        tick();
        n_cmp++; if (q4 !== 4'b1000) begin n_err++; $display("FAIL w4_q: got %b need 1000", q4); end
        n_cmp++; if (f4 !== 4'b0010) begin n_err++; $display("FAIL w4_forbid: got %b need 0010", f4); end
        n_cmp++; if (qb4 !== 4'b0111) begin n_err++; $display("FAIL w4_qbar: got %b need 0111", qb4); end
        s4 = 4'b0101; r4 = 4'b1000;
        tick();
        n_cmp++; if ({q4, f4} !== 8'b0101_0000) begin n_err++; $display("FAIL w4_step2: got q=%b f=%b need 0101/0000", q4, f4); end
        s4 = 4'b0000; r4 = 4'b0000;
        tick();
        n_cmp++; if ({q4, qb4} !== 8'b0101_1010) begin n_err++; $display("FAIL w4_hold: got q=%b qb=%b need 0101/1010", q4, qb4); end
    endtask

    initial begin
        s0 = 0; r0 = 0; s1 = 0; r1 = 0; s2 = 0; r2 = 0; s3 = 0; r3 = 0;
        s4 = '0; r4 = '0;
        test_reset();
        test_hold_set_reset();
        test_forbid_mode0();
        test_forbid_other_modes();
        test_async_reset();
        test_between_edges();
        test_width4();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
